btb_2way: RTL and testbench
===========================

// Module: btb_2way
// PURPOSE
//  Next-generation Branch Target Buffer (BTB) for the fetch stage.
//  - Parametrised, tagged, 2-way set-associative cache of taken-branch targets.
//  - Fetch PC lookup is combinational (same cycle). Decode-stage updates are synchronous.
//  - Adds per-entry valid bits, tag compare, a hit flag, LRU replacement and a flush.
// PARAMETERS
//  PC_W   16  PC and target width in bits
//  IDX_W  3   set-index width; 2**IDX_W sets, 2 ways each (default 8 sets, 16 entries)
//  TAG_W  PC_W-IDX_W-1  derived; stored tag width (default 12)
// PORTS
//  clk               in   1      system clock, all state on rising edge
//  rst               in   1      synchronous reset, active-high
//  enable            in   1      0 = freeze all state (stall); lookup outputs stay live
//  PC_curr           in   PC_W   fetch-stage PC to look up
//  IF_ID_PC_curr     in   PC_W   PC of the branch being resolved in decode (update address)
//  wen               in   1      write actual_target for IF_ID_PC_curr (taken/mispredicted)
//  actual_target     in   PC_W   resolved branch target
//  flush             in   1      invalidate all entries
//  predicted_target  out  PC_W   target of hitting way; 0 on miss
//  hit               out  1      lookup hit
//  hit_way           out  1      way that hit; 0 on miss
// BEHAVIOUR
//  - Addressing: index = pc[IDX_W:1]; tag = pc[PC_W-1:IDX_W+1]; pc[0] is ignored (word-aligned).
//  - Lookup (comb.): hit = valid[w] & (tag[w]==tag(PC_curr)) for either way.
//    - Both ways cannot hold the same valid tag; the update rules guarantee this.
//  - Read-during-write: no bypass. Lookup shows pre-edge contents; new data is visible the cycle after wen.
//  - Update, on the clock edge when enable & wen & ~flush, into set index(IF_ID_PC_curr):
//    a) A valid way whose tag matches: overwrite its target in place.
//    b) Otherwise, an invalid way (way0 has priority over way1): write tag, target, set valid.
//    c) Otherwise, the LRU way is evicted and replaced.
//    - After any update, the LRU bit of that set points to the other way.
//  - LRU: one bit per set, naming the least-recently-used way.
//    - Lookup touch: when enable & hit, LRU[index(PC_curr)] <= ~hit_way.
//    - If the touch and an update hit the same set in the same cycle, the update wins.
//  - flush (when enable): all valid <= 0 and all LRU <= 0 at the next edge.
//    - flush has priority over wen; a write in the flush cycle is dropped.
//  - enable=0: no valid/tag/target/LRU changes, including flush and wen.
//  - Reset (any cycle, including mid-update): all valid=0, LRU=0.
//    - Tag and target arrays need not be reset.
//    - Next cycle: hit=0, hit_way=0, predicted_target=0 for every PC.
//  - Latency: lookup 0 cycles; update visible 1 cycle after the write edge.
// STRUCTURE
//  - Package btb_pkg:
//    - default PC_W and IDX_W;
//    - typedef btb_entry_t {valid, tag[TAG_W], target[PC_W]};
//    - localparams NUM_SETS and TAG_W.
//  - Sub-module btb_way:
//    - one way's arrays: valid, tag and target;
//    - async read port producing a match and the target for a given index/tag;
//    - sync write port and clear-all for flush/rst.
//  - btb_2way instantiates two btb_way instances plus the LRU vector and the victim-select logic.
// TESTING (defaults PC_W=16, IDX_W=3)
//  1. rst, then look up 0x0004 -> hit=0, hit_way=0, predicted_target=0x0000.
//  2. wen IF_ID_PC=0x0004, tgt=0x0040; next cycle look up 0x0004 -> hit=1, way0, 0x0040.
//     - Look up 0x1004 (same set, new tag) -> hit=0.
//  3. Eviction (continuing from 2):
//     - Write 0x1004 -> 0x0100: goes to way1.
//     - Look up 0x0004 with enable=1: touch makes way1 the LRU.
//     - Write 0x2004 -> 0x0200: replaces way1.
//     - Result: 0x1004 misses, 0x0004 hits 0x0040, 0x2004 hits way1 0x0200.
//  4. Same-tag write 0x0004 -> 0x0080 -> 0x0004 hits way0 with 0x0080; 0x2004 still hits.
//  5. flush=1 and wen (0x0006 -> 0x0300) in the same cycle -> all PCs miss; 0x0006 misses.
//  6. enable=0 with wen (0x0008 -> 0x0400) -> 0x0008 misses.
//     - Then assert rst during a wen cycle -> every lookup misses afterwards.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared defaults and types for the 2-way branch target buffer.
package btb_pkg;

    // Default geometry: 16-bit PCs, 8 sets of 2 ways.
    localparam int unsigned DEF_PC_W  = 16;
    localparam int unsigned DEF_IDX_W = 3;

    // Derived sizes for the default geometry.
    localparam int unsigned TAG_W    = DEF_PC_W - DEF_IDX_W - 1;
    localparam int unsigned NUM_SETS = 2 ** DEF_IDX_W;

    // One BTB entry at the default geometry.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DEF_PC_W-1:0] target;
    } btb_entry_t;

    // One LRU bit per set at the default geometry.
    typedef logic [NUM_SETS-1:0] lru_vec_t;

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: valid/tag/target arrays with an asynchronous lookup port,
// an asynchronous probe of the update set, a synchronous write port and a clear-all.
module btb_way
    import btb_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned IDX_W = DEF_IDX_W,
    localparam int unsigned TagW    = PC_W - IDX_W - 1,
    localparam int unsigned NumSets = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             clear,
    // lookup port
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TagW-1:0]  rd_tag,
    output logic             rd_hit,
    output logic [PC_W-1:0]  rd_target,
    // update port
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TagW-1:0]  wr_tag,
    input  logic [PC_W-1:0]  wr_target,
    output logic             wr_hit,
    output logic             wr_valid
);

    logic [NumSets-1:0] valid_q;
    logic [TagW-1:0]    tag_q    [NumSets];
    logic [PC_W-1:0]    target_q [NumSets];

    // Valid bits: cleared by reset/flush, set by a write.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and target storage is never reset; valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (we && !clear) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

    // Lookup sees pre-edge contents only; there is no write bypass.
    always_comb begin
        rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_target = target_q[rd_idx];
    end

    // Probe of the update set used by the victim selection.
    always_comb begin
        wr_valid = valid_q[wr_idx];
        wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    end

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative branch target buffer with combinational lookup,
// synchronous update, per-set LRU replacement and flush.
module btb_2way
    import btb_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned IDX_W = DEF_IDX_W,
    localparam int unsigned TagW    = PC_W - IDX_W - 1,
    localparam int unsigned NumSets = 2 ** IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [PC_W-1:0] PC_curr,
    input  logic [PC_W-1:0] IF_ID_PC_curr,
    input  logic            wen,
    input  logic [PC_W-1:0] actual_target,
    input  logic            flush,
    output logic [PC_W-1:0] predicted_target,
    output logic            hit,
    output logic            hit_way
);

    logic [IDX_W-1:0] rd_idx;
    logic [TagW-1:0]  rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TagW-1:0]  wr_tag;

    // pc[0] is never used: PCs are word-aligned.
    logic unused_pc_lsb;
    assign unused_pc_lsb = PC_curr[0] ^ IF_ID_PC_curr[0];

    assign rd_idx = PC_curr[IDX_W:1];
    assign rd_tag = PC_curr[PC_W-1:IDX_W+1];
    assign wr_idx = IF_ID_PC_curr[IDX_W:1];
    assign wr_tag = IF_ID_PC_curr[PC_W-1:IDX_W+1];

    logic               clear;
    logic               upd;
    logic               victim;
    logic               we0;
    logic               we1;
    logic               rd_hit0;
    logic               rd_hit1;
    logic [PC_W-1:0]    rd_target0;
    logic [PC_W-1:0]    rd_target1;
    logic               wr_hit0;
    logic               wr_hit1;
    logic               wr_valid0;
    logic               wr_valid1;
    logic [NumSets-1:0] lru_q;

    // Flush is only honoured while enabled; reset always wins.
    assign clear = rst || (enable && flush);
    assign upd   = enable && wen && !flush && !rst;
    assign we0   = upd && (victim == 1'b0);
    assign we1   = upd && (victim == 1'b1);

    btb_way #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_way0 (
        .clk       (clk),
        .clear     (clear),
        .rd_idx    (rd_idx),
        .rd_tag    (rd_tag),
        .rd_hit    (rd_hit0),
        .rd_target (rd_target0),
        .we        (we0),
        .wr_idx    (wr_idx),
        .wr_tag    (wr_tag),
        .wr_target (actual_target),
        .wr_hit    (wr_hit0),
        .wr_valid  (wr_valid0)
    );

    btb_way #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_way1 (
        .clk       (clk),
        .clear     (clear),
        .rd_idx    (rd_idx),
        .rd_tag    (rd_tag),
        .rd_hit    (rd_hit1),
        .rd_target (rd_target1),
        .we        (we1),
        .wr_idx    (wr_idx),
        .wr_tag    (wr_tag),
        .wr_target (actual_target),
        .wr_hit    (wr_hit1),
        .wr_valid  (wr_valid1)
    );

    // Lookup result: at most one way can match, way0 checked first.
    always_comb begin
        hit              = rd_hit0 || rd_hit1;
        hit_way          = !rd_hit0 && rd_hit1;
        predicted_target = '0;
        if (rd_hit0) begin
            predicted_target = rd_target0;
        end else if (rd_hit1) begin
            predicted_target = rd_target1;
        end
    end

    // Victim: matching way, else first invalid way, else the set's LRU way.
    always_comb begin
        victim = lru_q[wr_idx];
        if (wr_hit0) begin
            victim = 1'b0;
        end else if (wr_hit1) begin
            victim = 1'b1;
        end else if (!wr_valid0) begin
            victim = 1'b0;
        end else if (!wr_valid1) begin
            victim = 1'b1;
        end
    end

    // LRU bits: lookup touch then update, so an update to the same set wins.
    always_ff @(posedge clk) begin
        if (clear) begin
            lru_q <= '0;
        end else if (enable) begin
            if (hit) begin
                lru_q[rd_idx] <= !hit_way;
            end
            if (upd) begin
                lru_q[wr_idx] <= !victim;
            end
        end
    end

    // The update rules never leave one tag valid in both ways of a set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rd_hit0 && rd_hit1))
                else $error("btb_2way: tag valid in both ways");
        end
    end

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: directed vectors with literal expectations
// plus a recency-list model compared against the lookup outputs every cycle.
module tb_btb_2way;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TAG_W = PC_W - IDX_W - 1;
    localparam int unsigned SETS  = 2 ** IDX_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [PC_W-1:0] PC_curr = '0;
    logic [PC_W-1:0] IF_ID_PC_curr = '0;
    logic            wen = 1'b0;
    logic [PC_W-1:0] actual_target = '0;
    logic            flush = 1'b0;
    logic [PC_W-1:0] predicted_target;
    logic            hit;
    logic            hit_way;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    btb_2way dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .PC_curr          (PC_curr),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .wen              (wen),
        .actual_target    (actual_target),
        .flush            (flush),
        .predicted_target (predicted_target),
        .hit              (hit),
        .hit_way          (hit_way)
    );

    always #5 clk = ~clk;

    // Model: each set is a list of resident entries, most recently used first.
    typedef struct {
        logic             way;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  tgt;
    } ent_t;

    ent_t sets [SETS][$];

    function automatic int find(int s, logic [TAG_W-1:0] t);
        for (int i = 0; i < sets[s].size(); i++) begin
            if (sets[s][i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic model_lookup(input logic [PC_W-1:0] pc, output logic h,
                                output logic w, output logic [PC_W-1:0] t);
        int s;
        int p;
        s = int'(pc[IDX_W:1]);
        p = find(s, pc[PC_W-1:IDX_W+1]);
        h = 1'b0;
        w = 1'b0;
        t = '0;
        if (p >= 0) begin
            h = 1'b1;
            w = sets[s][p].way;
            t = sets[s][p].tgt;
        end
    endtask

    task automatic move_front(input int s, input int p);
        ent_t e;
        e = sets[s][p];
        sets[s].delete(p);
        sets[s].push_front(e);
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) sets[s].delete();
    endtask

    // Advance the model by one clock edge using the inputs now being presented.
    task automatic model_step();
        int rs;
        int rp;
        int ws;
        int wp;
        logic vway;
        logic [TAG_W-1:0] wtag;
        ent_t e;
        if (rst) begin
            model_clear();
        end else if (enable) begin
            if (flush) begin
                model_clear();
            end else begin
                ws   = int'(IF_ID_PC_curr[IDX_W:1]);
                wtag = IF_ID_PC_curr[PC_W-1:IDX_W+1];
                wp   = find(ws, wtag);
                vway = 1'b0;
                // Replacement choice uses the recency order before this edge.
                if (wen && wp < 0) begin
                    if (sets[ws].size() == 0) vway = 1'b0;
                    else if (sets[ws].size() == 1) vway = ~sets[ws][0].way;
                    else vway = sets[ws][sets[ws].size()-1].way;
                end
                rs = int'(PC_curr[IDX_W:1]);
                rp = find(rs, PC_curr[PC_W-1:IDX_W+1]);
                if (rp >= 0) move_front(rs, rp);
                if (wen) begin
                    wp = find(ws, wtag);
                    if (wp >= 0) begin
                        sets[ws][wp].tgt = actual_target;
                        move_front(ws, wp);
                    end else begin
                        if (sets[ws].size() == 2) begin
                            if (sets[ws][0].way == vway) sets[ws].delete(0);
                            else sets[ws].delete(1);
                        end
                        e.way = vway;
                        e.tag = wtag;
                        e.tgt = actual_target;
                        sets[ws].push_front(e);
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: away from the active edge, check outputs then step the model.
    initial begin
        logic            eh;
        logic            ew;
        logic [PC_W-1:0] et;
        forever begin
            @(negedge clk);
            if (started) begin
                model_lookup(PC_curr, eh, ew, et);
                check("model.hit", 32'(hit), 32'(eh));
                check("model.hit_way", 32'(hit_way), 32'(ew));
                check("model.target", 32'(predicted_target), 32'(et));
            end
            model_step();
            if (rst) started = 1'b1;
        end
    end

    // One cycle of stimulus, held from just after one edge to just after the next.
    task automatic cyc(input logic en, input logic r, input logic fl, input logic w,
                       input logic [PC_W-1:0] ifpc, input logic [PC_W-1:0] tgt,
                       input logic [PC_W-1:0] pc);
        enable        = en;
        rst           = r;
        flush         = fl;
        wen           = w;
        IF_ID_PC_curr = ifpc;
        actual_target = tgt;
        PC_curr       = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [PC_W-1:0] ifpc, input logic [PC_W-1:0] tgt);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, ifpc, tgt, 16'hFFF0);
    endtask

    // Literal lookup check with enable high (so a hit also touches the LRU).
    task automatic chk(input string name, input logic [PC_W-1:0] pc, input logic h,
                       input logic w, input logic [PC_W-1:0] t);
        enable  = 1'b1;
        rst     = 1'b0;
        flush   = 1'b0;
        wen     = 1'b0;
        PC_curr = pc;
        #1;
        check({name, ".hit"}, 32'(hit), 32'(h));
        check({name, ".way"}, 32'(hit_way), 32'(w));
        check({name, ".tgt"}, 32'(predicted_target), 32'(t));
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

        // Reset state.
        chk("rst_0004", 16'h0004, 1'b0, 1'b0, 16'h0000);

        // First fill goes to way0; different tag in the same set misses.
        wr(16'h0004, 16'h0040);
        chk("fill_0004", 16'h0004, 1'b1, 1'b0, 16'h0040);
        chk("miss_1004", 16'h1004, 1'b0, 1'b0, 16'h0000);

        // Second tag fills way1; touching 0x0004 makes way1 LRU; 0x2004 evicts it.
        wr(16'h1004, 16'h0100);
        chk("fill_1004", 16'h1004, 1'b1, 1'b1, 16'h0100);
        chk("touch_0004", 16'h0004, 1'b1, 1'b0, 16'h0040);
        wr(16'h2004, 16'h0200);
        chk("evict_1004", 16'h1004, 1'b0, 1'b0, 16'h0000);
        chk("keep_0004", 16'h0004, 1'b1, 1'b0, 16'h0040);
        chk("new_2004", 16'h2004, 1'b1, 1'b1, 16'h0200);

        // Same-tag write overwrites in place.
        wr(16'h0004, 16'h0080);
        chk("inplace_0004", 16'h0004, 1'b1, 1'b0, 16'h0080);
        chk("still_2004", 16'h2004, 1'b1, 1'b1, 16'h0200);

        // Flush beats a simultaneous write.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0006, 16'h0300, 16'h0004);
        chk("flush_0004", 16'h0004, 1'b0, 1'b0, 16'h0000);
        chk("flush_2004", 16'h2004, 1'b0, 1'b0, 16'h0000);
        chk("flush_0006", 16'h0006, 1'b0, 1'b0, 16'h0000);

        // Touch and update to the same set in one cycle: victim is the pre-edge LRU.
        wr(16'h0004, 16'h0040);
        wr(16'h1004, 16'h0100);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h2004, 16'h0200, 16'h0004);
        chk("coll_0004", 16'h0004, 1'b0, 1'b0, 16'h0000);
        chk("coll_1004", 16'h1004, 1'b1, 1'b1, 16'h0100);
        chk("coll_2004", 16'h2004, 1'b1, 1'b0, 16'h0200);

        // Stall drops the write but lookups stay live.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 16'h0400, 16'h0008);
        chk("stall_0008", 16'h0008, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1004);
        chk("stallfl_1004", 16'h1004, 1'b1, 1'b1, 16'h0100);

        // Reset during a write cycle.
        wr(16'h000A, 16'h0500);
        chk("fill_000a", 16'h000A, 1'b1, 1'b0, 16'h0500);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h000C, 16'h0600, 16'h000A);
        chk("rst_000a", 16'h000A, 1'b0, 1'b0, 16'h0000);
        chk("rst_000c", 16'h000C, 1'b0, 1'b0, 16'h0000);
        chk("rst_1004", 16'h1004, 1'b0, 1'b0, 16'h0000);

        // Mixed traffic over a small tag pool, checked by the model each cycle.
        for (int n = 0; n < 300; n++) begin
            logic [PC_W-1:0] a;
            logic [PC_W-1:0] b;
            a = {10'($urandom_range(0, 2)), 2'b00, 3'($urandom_range(0, 7)), 1'($urandom)};
            b = {10'($urandom_range(0, 2)), 2'b00, 3'($urandom_range(0, 7)), 1'($urandom)};
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 39) == 0), 1'($urandom), a, 16'($urandom), b);
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
